branch_rs: RTL and testbench

- Reservation station dedicated to branch/jump micro-ops; sits directly upstream of the branch execution unit.
- Buffers dispatched branches, captures source operands from dispatch or the common data bus (CDB), and issues the oldest fully-ready entry.
- Drives the branch unit's operand/PC/imm/op/tag inputs through a registered issue stage.
- Flushed wholesale on misprediction recovery.

---
 rtl/branch_rs.sv | 273 +++++++++++++++++++++++++++
 tb/tb_branch_rs.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_rs.sv
// branch_rs: reservation station for branch/jump micro-ops.
// Compacting age-ordered queue where slot 0 is the oldest entry. Source
// operands are captured at dispatch or from the CDB. The oldest fully-ready
// entry is issued through a registered stage into the branch unit.
// Optional build macro BRS_WAKEUP_BYPASS_EN: select also sees the live CDB
// broadcast, so an entry can issue in the same cycle it is woken.
module branch_rs #(
    parameter int DATA_WIDTH = 32,
    parameter int ROB_WIDTH  = 4,
    parameter int PREG_WIDTH = 7,
    parameter int DEPTH      = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_flush,
    input  logic                       i_disp_valid,
    output logic                       o_disp_ready,
    input  logic [DATA_WIDTH-1:0]      i_disp_pc,
    input  logic [DATA_WIDTH-1:0]      i_disp_imm,
    input  logic [3:0]                 i_disp_alu_op,
    input  logic [ROB_WIDTH-1:0]       i_disp_rob_tag,
    input  logic [PREG_WIDTH-1:0]      i_disp_prd,
    input  logic [PREG_WIDTH-1:0]      i_disp_prs1,
    input  logic [PREG_WIDTH-1:0]      i_disp_prs2,
    input  logic                       i_disp_rs1_rdy,
    input  logic                       i_disp_rs2_rdy,
    input  logic [DATA_WIDTH-1:0]      i_disp_rs1_val,
    input  logic [DATA_WIDTH-1:0]      i_disp_rs2_val,
    input  logic                       i_cdb_valid,
    input  logic [PREG_WIDTH-1:0]      i_cdb_prd,
    input  logic [DATA_WIDTH-1:0]      i_cdb_data,
    output logic                       o_valid,
    output logic [DATA_WIDTH-1:0]      o_op1,
    output logic [DATA_WIDTH-1:0]      o_op2,
    output logic [DATA_WIDTH-1:0]      o_pc,
    output logic [DATA_WIDTH-1:0]      o_imm,
    output logic [3:0]                 o_alu_op,
    output logic [ROB_WIDTH-1:0]       o_rob_tag,
    output logic [PREG_WIDTH-1:0]      o_prd,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] imm;
        logic [3:0]            alu_op;
        logic [ROB_WIDTH-1:0]  rob_tag;
        logic [PREG_WIDTH-1:0] prd;
        logic [PREG_WIDTH-1:0] prs1;
        logic [PREG_WIDTH-1:0] prs2;
        logic                  rdy1;
        logic                  rdy2;
        logic [DATA_WIDTH-1:0] val1;
        logic [DATA_WIDTH-1:0] val2;
    } entry_t;

    // Entry storage; an entry is valid exactly when its slot index < count.
    entry_t                ent_q [DEPTH];
    entry_t                ent_d [DEPTH];
    entry_t                ent_wk [DEPTH];
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;

    // Wakeup / select / dispatch signals
    logic                  cdb_live;
    logic [DEPTH-1:0]      hit1;
    logic [DEPTH-1:0]      hit2;
    logic [DEPTH-1:0]      can_issue;
    logic                  issue;
    logic [IW-1:0]         sel_idx;
    logic                  accept;
    logic [CW-1:0]         ins_pos;
    entry_t                new_ent;

    // Issue register
    logic                  iss_valid_q,  iss_valid_d;
    logic [DATA_WIDTH-1:0] iss_op1_q,    iss_op1_d;
    logic [DATA_WIDTH-1:0] iss_op2_q,    iss_op2_d;
    logic [DATA_WIDTH-1:0] iss_pc_q,     iss_pc_d;
    logic [DATA_WIDTH-1:0] iss_imm_q,    iss_imm_d;
    logic [3:0]            iss_alu_op_q, iss_alu_op_d;
    logic [ROB_WIDTH-1:0]  iss_rob_q,    iss_rob_d;
    logic [PREG_WIDTH-1:0] iss_prd_q,    iss_prd_d;

    assign o_disp_ready = (count_q < CW'(DEPTH));
    assign o_count      = count_q;
    assign o_valid      = iss_valid_q;
    assign o_op1        = iss_op1_q;
    assign o_op2        = iss_op2_q;
    assign o_pc         = iss_pc_q;
    assign o_imm        = iss_imm_q;
    assign o_alu_op     = iss_alu_op_q;
    assign o_rob_tag    = iss_rob_q;
    assign o_prd        = iss_prd_q;

    // CDB wakeup: produce a woken copy of every stored entry.
    always_comb begin
        cdb_live = i_cdb_valid && (i_cdb_prd != '0);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            hit1[i]   = cdb_live && (CW'(i) < count_q) && !ent_q[i].rdy1
                        && (ent_q[i].prs1 == i_cdb_prd);
            hit2[i]   = cdb_live && (CW'(i) < count_q) && !ent_q[i].rdy2
                        && (ent_q[i].prs2 == i_cdb_prd);
            ent_wk[i] = ent_q[i];
            if (hit1[i]) begin
                ent_wk[i].rdy1 = 1'b1;
                ent_wk[i].val1 = i_cdb_data;
            end
            if (hit2[i]) begin
                ent_wk[i].rdy2 = 1'b1;
                ent_wk[i].val2 = i_cdb_data;
            end
        end
    end

    // Select the lowest-index (oldest) entry with both sources ready.
    always_comb begin
        issue   = 1'b0;
        sel_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
`ifdef BRS_WAKEUP_BYPASS_EN
            can_issue[i] = (CW'(i) < count_q)
                           && (ent_q[i].rdy1 || hit1[i])
                           && (ent_q[i].rdy2 || hit2[i]);
`else
            can_issue[i] = (CW'(i) < count_q) && ent_q[i].rdy1 && ent_q[i].rdy2;
`endif
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (can_issue[i] && !issue) begin
                issue   = 1'b1;
                sel_idx = IW'(i);
            end
        end
    end

    // Build the incoming entry; prs 0 is hard-wired zero, a matching CDB
    // broadcast beats the dispatch-supplied ready/value.
    always_comb begin
        accept          = i_disp_valid && o_disp_ready;
        new_ent         = '0;
        new_ent.pc      = i_disp_pc;
        new_ent.imm     = i_disp_imm;
        new_ent.alu_op  = i_disp_alu_op;
        new_ent.rob_tag = i_disp_rob_tag;
        new_ent.prd     = i_disp_prd;
        new_ent.prs1    = i_disp_prs1;
        new_ent.prs2    = i_disp_prs2;
        if (i_disp_prs1 == '0) begin
            new_ent.rdy1 = 1'b1;
            new_ent.val1 = '0;
        end else if (i_cdb_valid && (i_cdb_prd == i_disp_prs1)) begin
            new_ent.rdy1 = 1'b1;
            new_ent.val1 = i_cdb_data;
        end else begin
            new_ent.rdy1 = i_disp_rs1_rdy;
            new_ent.val1 = i_disp_rs1_val;
        end
        if (i_disp_prs2 == '0) begin
            new_ent.rdy2 = 1'b1;
            new_ent.val2 = '0;
        end else if (i_cdb_valid && (i_cdb_prd == i_disp_prs2)) begin
            new_ent.rdy2 = 1'b1;
            new_ent.val2 = i_cdb_data;
        end else begin
            new_ent.rdy2 = i_disp_rs2_rdy;
            new_ent.val2 = i_disp_rs2_val;
        end
    end

    // Next queue contents: compact over the issued slot, then append at the tail.
    always_comb begin
        ins_pos = count_q - CW'(issue);
        for (int unsigned i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_wk[i];
        end
        if (issue) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                if (IW'(i) >= sel_idx) begin
                    ent_d[i] = ent_wk[i + 1];
                end
            end
        end
        if (accept) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (CW'(i) == ins_pos) begin
                    ent_d[i] = new_ent;
                end
            end
        end
    end

    // Occupancy; a flush empties the queue and discards dispatch and issue.
    always_comb begin
        if (i_flush) begin
            count_d = '0;
        end else begin
            count_d = count_q + CW'(accept) - CW'(issue);
        end
    end

    // Issue register next state; payload is held when nothing issues.
    always_comb begin
        iss_valid_d  = 1'b0;
        iss_op1_d    = iss_op1_q;
        iss_op2_d    = iss_op2_q;
        iss_pc_d     = iss_pc_q;
        iss_imm_d    = iss_imm_q;
        iss_alu_op_d = iss_alu_op_q;
        iss_rob_d    = iss_rob_q;
        iss_prd_d    = iss_prd_q;
        if (!i_flush && issue) begin
            iss_valid_d  = 1'b1;
            iss_op1_d    = ent_q[sel_idx].val1;
            iss_op2_d    = ent_q[sel_idx].val2;
`ifdef BRS_WAKEUP_BYPASS_EN
            if (!ent_q[sel_idx].rdy1) begin
                iss_op1_d = i_cdb_data;
            end
            if (!ent_q[sel_idx].rdy2) begin
                iss_op2_d = i_cdb_data;
            end
`endif
            iss_pc_d     = ent_q[sel_idx].pc;
            iss_imm_d    = ent_q[sel_idx].imm;
            iss_alu_op_d = ent_q[sel_idx].alu_op;
            iss_rob_d    = ent_q[sel_idx].rob_tag;
            iss_prd_d    = ent_q[sel_idx].prd;
        end
    end

    // Entry storage and occupancy registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            count_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            count_q <= count_d;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
        end
    end

    // Issue stage registers driving the branch unit.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            iss_valid_q  <= 1'b0;
            iss_op1_q    <= '0;
            iss_op2_q    <= '0;
            iss_pc_q     <= '0;
            iss_imm_q    <= '0;
            iss_alu_op_q <= '0;
            iss_rob_q    <= '0;
            iss_prd_q    <= '0;
        end else begin
            iss_valid_q  <= iss_valid_d;
            iss_op1_q    <= iss_op1_d;
            iss_op2_q    <= iss_op2_d;
            iss_pc_q     <= iss_pc_d;
            iss_imm_q    <= iss_imm_d;
            iss_alu_op_q <= iss_alu_op_d;
            iss_rob_q    <= iss_rob_d;
            iss_prd_q    <= iss_prd_d;
        end
    end

endmodule

// File: tb/tb_branch_rs.sv
// Testbench for branch_rs: scoreboard of expected issues, each tagged with
// the clock edge at which it must appear on the issue outputs.
module tb_branch_rs;

    localparam int DW    = 32;
    localparam int RW    = 4;
    localparam int PW    = 7;
    localparam int DEPTH = 4;
`ifdef BRS_WAKEUP_BYPASS_EN
    localparam int WAKE_LAT = 1;
`else
    localparam int WAKE_LAT = 2;
`endif

    logic          i_clk;
    logic          i_rst;
    logic          i_flush;
    logic          i_disp_valid;
    logic          o_disp_ready;
    logic [DW-1:0] i_disp_pc;
    logic [DW-1:0] i_disp_imm;
    logic [3:0]    i_disp_alu_op;
    logic [RW-1:0] i_disp_rob_tag;
    logic [PW-1:0] i_disp_prd;
    logic [PW-1:0] i_disp_prs1;
    logic [PW-1:0] i_disp_prs2;
    logic          i_disp_rs1_rdy;
    logic          i_disp_rs2_rdy;
    logic [DW-1:0] i_disp_rs1_val;
    logic [DW-1:0] i_disp_rs2_val;
    logic          i_cdb_valid;
    logic [PW-1:0] i_cdb_prd;
    logic [DW-1:0] i_cdb_data;
    logic          o_valid;
    logic [DW-1:0] o_op1;
    logic [DW-1:0] o_op2;
    logic [DW-1:0] o_pc;
    logic [DW-1:0] o_imm;
    logic [3:0]    o_alu_op;
    logic [RW-1:0] o_rob_tag;
    logic [PW-1:0] o_prd;
    logic [$clog2(DEPTH+1)-1:0] o_count;

    branch_rs #(
        .DATA_WIDTH(DW),
        .ROB_WIDTH (RW),
        .PREG_WIDTH(PW),
        .DEPTH     (DEPTH)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_flush       (i_flush),
        .i_disp_valid  (i_disp_valid),
        .o_disp_ready  (o_disp_ready),
        .i_disp_pc     (i_disp_pc),
        .i_disp_imm    (i_disp_imm),
        .i_disp_alu_op (i_disp_alu_op),
        .i_disp_rob_tag(i_disp_rob_tag),
        .i_disp_prd    (i_disp_prd),
        .i_disp_prs1   (i_disp_prs1),
        .i_disp_prs2   (i_disp_prs2),
        .i_disp_rs1_rdy(i_disp_rs1_rdy),
        .i_disp_rs2_rdy(i_disp_rs2_rdy),
        .i_disp_rs1_val(i_disp_rs1_val),
        .i_disp_rs2_val(i_disp_rs2_val),
        .i_cdb_valid   (i_cdb_valid),
        .i_cdb_prd     (i_cdb_prd),
        .i_cdb_data    (i_cdb_data),
        .o_valid       (o_valid),
        .o_op1         (o_op1),
        .o_op2         (o_op2),
        .o_pc          (o_pc),
        .o_imm         (o_imm),
        .o_alu_op      (o_alu_op),
        .o_rob_tag     (o_rob_tag),
        .o_prd         (o_prd),
        .o_count       (o_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [DW-1:0] op1;
        logic [DW-1:0] op2;
        logic [DW-1:0] pc;
        logic [DW-1:0] imm;
        logic [3:0]    op;
        logic [RW-1:0] rob;
        logic [PW-1:0] prd;
        int            at_edge;
    } exp_t;

    exp_t sb [$];
    exp_t cur;
    logic exp_v;
    int   total = 0;
    int   bad   = 0;
    int   edges = 0;

    task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Issue monitor: sampled 1 time unit after every rising edge.
    always @(posedge i_clk) begin
        edges++;
        #1;
        while (sb.size() != 0 && sb[0].at_edge < edges) sb.delete(0);
        exp_v = (sb.size() != 0) && (sb[0].at_edge == edges);
        check_eq("o_valid", DW'(o_valid), DW'(exp_v));
        if (o_valid && exp_v) begin
            cur = sb[0];
            sb.delete(0);
            check_eq("o_op1", o_op1, cur.op1);
            check_eq("o_op2", o_op2, cur.op2);
            check_eq("o_pc", o_pc, cur.pc);
            check_eq("o_imm", o_imm, cur.imm);
            check_eq("o_alu_op", DW'(o_alu_op), DW'(cur.op));
            check_eq("o_rob_tag", DW'(o_rob_tag), DW'(cur.rob));
            check_eq("o_prd", DW'(o_prd), DW'(cur.prd));
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #2;
    endtask

    task automatic idle();
        i_disp_valid = 1'b0;
        i_cdb_valid  = 1'b0;
        i_flush      = 1'b0;
    endtask

    task automatic drive_disp(input logic [3:0] op, input logic [DW-1:0] pc, input logic [DW-1:0] imm,
                              input logic [RW-1:0] rob, input logic [PW-1:0] prd,
                              input logic [PW-1:0] prs1, input logic r1, input logic [DW-1:0] v1,
                              input logic [PW-1:0] prs2, input logic r2, input logic [DW-1:0] v2);
        i_disp_valid   = 1'b1;
        i_disp_alu_op  = op;
        i_disp_pc      = pc;
        i_disp_imm     = imm;
        i_disp_rob_tag = rob;
        i_disp_prd     = prd;
        i_disp_prs1    = prs1;
        i_disp_rs1_rdy = r1;
        i_disp_rs1_val = v1;
        i_disp_prs2    = prs2;
        i_disp_rs2_rdy = r2;
        i_disp_rs2_val = v2;
    endtask

    task automatic drive_cdb(input logic [PW-1:0] prd, input logic [DW-1:0] data);
        i_cdb_valid = 1'b1;
        i_cdb_prd   = prd;
        i_cdb_data  = data;
    endtask

    // Expect an issue lat edges after the edge that precedes the current cycle.
    task automatic push_exp(input logic [DW-1:0] op1, input logic [DW-1:0] op2, input logic [DW-1:0] pc,
                            input logic [DW-1:0] imm, input logic [3:0] op, input logic [RW-1:0] rob,
                            input logic [PW-1:0] prd, input int lat);
        exp_t e;
        e.op1 = op1; e.op2 = op2; e.pc = pc; e.imm = imm;
        e.op = op; e.rob = rob; e.prd = prd; e.at_edge = edges + lat;
        sb.push_back(e);
    endtask

    task automatic wait_drain(input int max_cycles);
        int n = 0;
        while (sb.size() != 0 && n < max_cycles) begin
            tick();
            n++;
        end
        check_eq("drain", DW'(sb.size()), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        idle();
        drive_disp(4'h0, '0, '0, '0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
        i_disp_valid = 1'b0;
        i_cdb_prd  = '0;
        i_cdb_data = '0;
        repeat (3) @(posedge i_clk);
        #2;
        i_rst = 1'b0;

        // Reset state
        check_eq("rst_count", DW'(o_count), 32'h0);
        check_eq("rst_ready", DW'(o_disp_ready), 32'h1);
        check_eq("rst_pc", o_pc, 32'h0);
        check_eq("rst_op1", o_op1, 32'h0);
        check_eq("rst_rob", DW'(o_rob_tag), 32'h0);

        // BEQ with both sources ready: out two edges after dispatch
        drive_disp(4'b0000, 32'h100, 32'h20, 4'd3, 7'd0, 7'd5, 1'b1, 32'd5, 7'd6, 1'b1, 32'd5);
        push_exp(32'd5, 32'd5, 32'h100, 32'h20, 4'b0000, 4'd3, 7'd0, 2);
        tick(); idle();
        check_eq("beq_count_disp", DW'(o_count), 32'h1);
        wait_drain(10);
        check_eq("beq_count_end", DW'(o_count), 32'h0);

        // BNE waiting on prs1=12, woken by CDB
        drive_disp(4'b0001, 32'h200, 32'h40, 4'd4, 7'd0, 7'd12, 1'b0, 32'hBAD, 7'd13, 1'b1, 32'd9);
        tick(); idle();
        repeat (3) tick();
        check_eq("bne_wait_count", DW'(o_count), 32'h1);
        drive_cdb(7'd12, 32'h7);
        push_exp(32'h7, 32'd9, 32'h200, 32'h40, 4'b0001, 4'd4, 7'd0, WAKE_LAT);
        tick(); idle();
        wait_drain(10);

        // Fill all entries with waiting branches (A,B,C,D)
        drive_disp(4'b0100, 32'h300, 32'h10, 4'd8,  7'd0, 7'd20, 1'b0, 32'h0, 7'd30, 1'b1, 32'h30); tick();
        drive_disp(4'b0101, 32'h304, 32'h10, 4'd9,  7'd0, 7'd21, 1'b0, 32'h0, 7'd31, 1'b1, 32'h31); tick();
        drive_disp(4'b0110, 32'h308, 32'h10, 4'd10, 7'd0, 7'd22, 1'b0, 32'h0, 7'd32, 1'b1, 32'h32); tick();
        drive_disp(4'b0111, 32'h30C, 32'h10, 4'd11, 7'd0, 7'd20, 1'b0, 32'h0, 7'd33, 1'b1, 32'h33); tick();
        idle();
        check_eq("full_count", DW'(o_count), 32'h4);
        check_eq("full_ready", DW'(o_disp_ready), 32'h0);
        // Dispatch attempt while full must be dropped
        drive_disp(4'b1000, 32'h3F0, 32'h0, 4'd15, 7'd1, 7'd0, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0);
        tick(); idle();
        check_eq("full_blocked_count", DW'(o_count), 32'h4);

        // Wake entry 2 only: it issues first
        drive_cdb(7'd22, 32'h22);
        push_exp(32'h22, 32'h32, 32'h308, 32'h10, 4'b0110, 4'd10, 7'd0, WAKE_LAT);
        tick(); idle();
        wait_drain(10);
        check_eq("after_c_count", DW'(o_count), 32'h3);
        check_eq("after_c_ready", DW'(o_disp_ready), 32'h1);

        // Refill with E waiting on prs1=21
        drive_disp(4'b0000, 32'h310, 32'h10, 4'd12, 7'd0, 7'd21, 1'b0, 32'h0, 7'd34, 1'b1, 32'h34);
        tick(); idle();
        check_eq("refill_count", DW'(o_count), 32'h4);

        // Wake oldest and youngest-of-original together: A then D back to back
        drive_cdb(7'd20, 32'hA0);
        push_exp(32'hA0, 32'h30, 32'h300, 32'h10, 4'b0100, 4'd8,  7'd0, WAKE_LAT);
        push_exp(32'hA0, 32'h33, 32'h30C, 32'h10, 4'b0111, 4'd11, 7'd0, WAKE_LAT + 1);
        tick(); idle();
        wait_drain(10);
        check_eq("after_ad_count", DW'(o_count), 32'h2);

        // B (older) then E
        drive_cdb(7'd21, 32'hB1);
        push_exp(32'hB1, 32'h31, 32'h304, 32'h10, 4'b0101, 4'd9,  7'd0, WAKE_LAT);
        push_exp(32'hB1, 32'h34, 32'h310, 32'h10, 4'b0000, 4'd12, 7'd0, WAKE_LAT + 1);
        tick(); idle();
        wait_drain(10);
        check_eq("after_be_count", DW'(o_count), 32'h0);

        // prs1=0 forced ready/zero; same-cycle CDB capture of prs2
        drive_disp(4'b1000, 32'h400, 32'h800, 4'd5, 7'd33, 7'd0, 1'b0, 32'hDEAD, 7'd40, 1'b0, 32'h99);
        drive_cdb(7'd40, 32'h55);
        push_exp(32'h0, 32'h55, 32'h400, 32'h800, 4'b1000, 4'd5, 7'd33, 2);
        tick();
        // CDB value overrides a ready dispatch value
        drive_disp(4'b1001, 32'h500, 32'h4, 4'd6, 7'd34, 7'd41, 1'b1, 32'h1000, 7'd42, 1'b1, 32'h11);
        drive_cdb(7'd42, 32'h66);
        push_exp(32'h1000, 32'h66, 32'h500, 32'h4, 4'b1001, 4'd6, 7'd34, 2);
        tick(); idle();
        wait_drain(10);

        // Flush with three entries, a pending issue and a dispatch in the same cycle
        drive_disp(4'b0000, 32'h600, 32'h8, 4'd1, 7'd0, 7'd51, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0); tick();
        drive_disp(4'b0000, 32'h604, 32'h8, 4'd2, 7'd0, 7'd52, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0); tick();
        drive_disp(4'b0000, 32'h608, 32'h8, 4'd7, 7'd0, 7'd0,  1'b0, 32'h0, 7'd0, 1'b0, 32'h0); tick();
        idle();
        check_eq("preflush_count", DW'(o_count), 32'h3);
        drive_disp(4'b0000, 32'h60C, 32'h8, 4'd14, 7'd0, 7'd0, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0);
        i_flush = 1'b1;
        tick(); idle();
        check_eq("flush_count", DW'(o_count), 32'h0);
        check_eq("flush_valid", DW'(o_valid), 32'h0);
        check_eq("flush_hold_rob", DW'(o_rob_tag), 32'h6);
        check_eq("flush_hold_pc", o_pc, 32'h500);
        drive_cdb(7'd51, 32'h1); tick();
        drive_cdb(7'd52, 32'h2); tick();
        idle();
        repeat (2) tick();
        check_eq("postflush_count", DW'(o_count), 32'h0);

        // Asynchronous reset in the middle of a cycle with an issue on the outputs
        drive_disp(4'b0001, 32'h700, 32'h8, 4'd13, 7'd0, 7'd0, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0);
        push_exp(32'h0, 32'h0, 32'h700, 32'h8, 4'b0001, 4'd13, 7'd0, 2);
        tick();
        drive_disp(4'b0000, 32'h704, 32'h8, 4'd12, 7'd0, 7'd60, 1'b0, 32'h0, 7'd0, 1'b0, 32'h0);
        tick(); idle();
        check_eq("prerst_valid", DW'(o_valid), 32'h1);
        check_eq("prerst_count", DW'(o_count), 32'h1);
        #1 i_rst = 1'b1;
        #1;
        check_eq("arst_valid", DW'(o_valid), 32'h0);
        check_eq("arst_count", DW'(o_count), 32'h0);
        check_eq("arst_ready", DW'(o_disp_ready), 32'h1);
        check_eq("arst_pc", o_pc, 32'h0);
        check_eq("arst_imm", o_imm, 32'h0);
        check_eq("arst_rob", DW'(o_rob_tag), 32'h0);
        #1 i_rst = 1'b0;
        repeat (3) tick();
        check_eq("postrst_count", DW'(o_count), 32'h0);
        check_eq("sb_empty", DW'(sb.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
